pipeline_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipeline_stage_skid.sv | 120 ++++++++++++
 tb/tb_pipeline_stage_skid.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// The head entry drives the outputs; the skid entry absorbs one beat while downstream stalls.
module pipeline_stage_skid #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 12,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // State bits are {main_v, skid_v}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [1:0]          occ_q, occ_d;
  logic                accept;
  logic                consume;

  // in_ready depends only on flops, so out_ready never reaches it combinationally.
  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_data_q;
  assign out_ctrl  = state_q[1] ? main_ctrl_q : BUBBLE_CTRL;
  assign occupancy = occ_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // Data is left stale; only ctrl must be scrubbed so a killed entry cannot commit.
      state_d     = EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      skid_ctrl_d = BUBBLE_CTRL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    occ_d = {1'b0, state_d[1]} + {1'b0, state_d[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      skid_ctrl_q <= BUBBLE_CTRL;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      occ_q       <= occ_d;
    end
  end

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {EMPTY, ONE, FULL});

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_ctrl)));

  a_no_accept_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && state_q == FULL));

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Self-checking bench for pipeline_stage_skid: directed scenarios plus random valid/ready,
// all compared against a capacity-2 FIFO model held in a queue.
module tb_pipeline_stage_skid;

  localparam int          DATA_W = 96;
  localparam int          CTRL_W = 12;
  localparam logic [11:0] BUBBLE = 12'h0A5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  pipeline_stage_skid #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .BUBBLE_CTRL(BUBBLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs follow directly from the model's contents.
  task automatic check_outputs(input string ph);
    logic exp_v;
    exp_v = (model_q.size() != 0);
    chk({ph, ".out_valid"}, 128'(out_valid), 128'(exp_v));
    chk({ph, ".occupancy"}, 128'(occupancy), 128'(model_q.size()));
    chk({ph, ".in_ready"},  128'(in_ready),  128'(model_q.size() < 2));
    chk({ph, ".out_ctrl"},  128'(out_ctrl),  128'(exp_v ? model_q[0].c : BUBBLE));
    if (exp_v) chk({ph, ".out_data"}, 128'(out_data), 128'(model_q[0].d));
  endtask

  // Called at a negedge: drive, clock, update the model, then check at the next negedge.
  task automatic step(input string ph, input logic v, input logic [DATA_W-1:0] d,
                      input logic [CTRL_W-1:0] c, input logic r, input logic f);
    logic acc, con;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    acc = v && (model_q.size() < 2);
    con = r && (model_q.size() != 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (con) begin
        void'(model_q.pop_front());
        n_out++;
      end
      if (acc) model_q.push_back('{d: d, c: c});
    end
    @(negedge clk);
    check_outputs(ph);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset.out_data", 128'(out_data), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("idle");

    // Streaming: 1..8 back-to-back with out_ready high.
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, DATA_W'(i), CTRL_W'(12'h100 + i), 1'b1, 1'b0);
    step("stream_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    $display("T2 streaming done, %0d entries consumed", n_out);

    // Stall: fill with 0xA, 0xB, then release.
    step("stall", 1'b1, DATA_W'(32'hA), 12'h00A, 1'b0, 1'b0);
    step("stall", 1'b1, DATA_W'(32'hB), 12'h00B, 1'b0, 1'b0);
    step("stall_hold", 1'b1, DATA_W'(32'hEE), 12'h0EE, 1'b0, 1'b0);
    chk("stall.occ2", 128'(occupancy), 128'(2));
    step("release", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("release.in_ready", 128'(in_ready), 128'(1));
    step("release", 1'b0, '0, '0, 1'b1, 1'b0);
    $display("T3 stall/release done");

    // Flush FULL with a concurrent input.
    step("refill", 1'b1, DATA_W'(32'h21), 12'h021, 1'b0, 1'b0);
    step("refill", 1'b1, DATA_W'(32'h22), 12'h022, 1'b0, 1'b0);
    step("flush", 1'b1, DATA_W'(32'hC), 12'hFFF, 1'b0, 1'b1);
    chk("flush.out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
    step("post_flush", 1'b0, '0, '0, 1'b1, 1'b0);
    $display("T4 flush done");

    // Asynchronous reset while FULL.
    step("prefull", 1'b1, DATA_W'(32'h31), 12'h031, 1'b0, 1'b0);
    step("prefull", 1'b1, DATA_W'(32'h32), 12'h032, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_q.delete();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("after_reset");
    $display("T1 reset-mid-FULL done");

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), {$urandom, $urandom, $urandom},
           CTRL_W'($urandom), ($urandom_range(0, 99) < 55), ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 3; i++) step("final_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("final_empty", 128'(occupancy), 128'(0));
    $display("T5 random done, %0d entries consumed in total", n_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
